axi_read_slave_mux: RTL and testbench
=====================================

# axi_read_slave_mux

Parametrised read-path slave multiplexer for the AXI interconnect. It routes one master's AR/R channels to one of NUM_SLAVES slaves, selected by decoding the registered ARADDR against a per-slave base/mask map. It tracks a single outstanding burst and returns R beats from only the selected slave until RLAST. Unmapped addresses get a locally generated DECERR burst. It replaces the fixed single-slave pass-through in the interconnect read path.

## Interface
- DATA_WIDTH, 32, R data width
- ADDR_WIDTH, 32, AR address width
- ID_WIDTH, 1, AXI ID width
- USER_WIDTH, 1, RUSER width
- NUM_SLAVES, 2, number of slave ports (1..16)
- SLV_BASE, {NUM_SLAVES{ADDR_WIDTH'0}}, packed base addresses; slave i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- SLV_MASK, {NUM_SLAVES{ADDR_WIDTH'0}}, packed decode masks; slave i matches when (ARADDR & mask_i) == base_i
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- m_ARADDR  in  ADDR_WIDTH  master read address
- m_ARLEN  in  8  burst length minus one
- m_ARID  in  ID_WIDTH  read ID
- m_ARVALID  in  1  address valid
- m_ARREADY  out  1  address ready
- m_RID / m_RDATA / m_RRESP / m_RLAST / m_RUSER  out  ID_WIDTH / DATA_WIDTH / 2 / 1 / USER_WIDTH  muxed read data channel
- m_RVALID  out  1  read valid
- m_RREADY  in  1  master read ready
- s_ARVALID  out  NUM_SLAVES  per-slave address valid, one-hot or zero
- s_ARREADY  in  NUM_SLAVES  per-slave address ready
- s_RID / s_RDATA / s_RRESP / s_RLAST / s_RUSER  in  NUM_SLAVES× respective widths, packed  per-slave R channel
- s_RVALID  in  NUM_SLAVES  per-slave read valid
- s_RREADY  out  NUM_SLAVES  per-slave read ready, one-hot or zero

## Operation
- FSM states: IDLE, ADDR, DATA, ERR_AR, ERR_R.
- IDLE: on m_ARVALID, register sel_idx, ARLEN and ARID. The decode picks the lowest-index matching slave.
  - On a hit, go to ADDR.
  - On a miss, go to ERR_AR, or to ADDR with sel_idx=0 when DECERR is compiled out.
  - In IDLE, m_ARREADY=0.
- ADDR:
  - s_ARVALID[sel_idx]=m_ARVALID; m_ARREADY=s_ARREADY[sel_idx].
  - On the m_ARVALID & m_ARREADY handshake, go to DATA.
- DATA:
  - The m_R* signals and m_RVALID come from slave sel_idx; s_RREADY[sel_idx]=m_RREADY.
  - On m_RVALID & m_RREADY & m_RLAST, go to IDLE.
  - Beats from non-selected slaves are not acknowledged and not forwarded.
- ERR_AR: m_ARREADY=1 for one cycle; no s_ARVALID is asserted. Load beat_cnt=0, then go to ERR_R.
- ERR_R:
  - Outputs: m_RVALID=1, m_RRESP=2'b11, m_RID=latched ID, m_RDATA=0, m_RUSER=0, m_RLAST=(beat_cnt==latched ARLEN).
  - beat_cnt increments on each handshake (8-bit, cannot wrap past 255).
  - On the last handshake, go to IDLE.
- Only one outstanding transaction at a time; a new AR is not accepted until the current burst's RLAST handshake completes.
- A slave RVALID in IDLE/ADDR is ignored: s_RREADY stays 0.

## Timing
- Reset values (all asynchronous):
  - State = IDLE.
  - m_ARREADY=0, m_RVALID=0, m_RLAST=0, m_RRESP=0, m_RID=0, m_RDATA=0, m_RUSER=0.
  - s_ARVALID=0, s_RREADY=0.
  - sel_idx, latched length/ID and beat_cnt = 0.
- Decode latency is 1 cycle: AR arriving at cycle T gives the earliest m_ARREADY at T+1.
- From ADDR/DATA onward, ready/valid forwarding is combinational with zero added latency.
- R-channel outputs are driven to 0 whenever the state is not DATA or ERR_R.
- RLAST from IDLE: a new AR can be registered in the cycle after the RLAST handshake (one bubble).
- If reset asserts mid-burst, the block returns to IDLE immediately. The in-flight burst is abandoned, and slave-side recovery is the system's responsibility.
- A master that drops ARVALID in ADDR (protocol violation) leaves the FSM in ADDR with s_ARVALID following it.

## Configuration
- AXI_RMUX_DECERR_EN defined: unmapped addresses take the ERR_AR/ERR_R path and return ARLEN+1 DECERR beats.
- AXI_RMUX_DECERR_EN undefined: the ERR states and beat_cnt are not compiled, and unmapped addresses route to slave 0 (default slave).

## Structure
- The shared package axi_pkg holds:
  - resp_t enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11);
  - rmux_state_t enum;
  - AXI_LEN_W=8.
- One sub-module, axi_addr_decoder: combinational base/mask match producing hit and lowest-index sel_idx. It is reused by the future write-side mux.

## Test plan
- NUM_SLAVES=2 (slave0 0x0000_0000/0xF000_0000, slave1 0x1000_0000/0xF000_0000). AR 0x1000_0040, ARLEN=3 → only s_ARVALID[1] asserts, 4 beats forwarded, RLAST on the 4th, state returns to IDLE.
- Slave 0 asserts RVALID while slave 1 is selected → m_RVALID reflects only slave 1 and s_RREADY[0] stays 0.
- With DECERR enabled, AR 0x2000_0000, ARID=1, ARLEN=1 → ARREADY pulse, then 2 beats with RRESP=2'b11, RID=1, RDATA=0, RLAST on the 2nd. No s_ARVALID asserts.
- m_RREADY toggled 0/1 every cycle during an 8-beat burst → no beat lost or duplicated; the beat count equals ARLEN+1.
- ARESETn pulled low mid-DATA (beat 2 of 4) → all outputs 0 asynchronously. After release, a new AR to slave 0 completes normally.
- With DECERR disabled, the unmapped AR 0x2000_0000 routes to slave 0 with an OKAY response.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI types and constants for the interconnect read/write slave muxes.
package axi_pkg;

  localparam int AXI_LEN_W = 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    ERR_AR,
    ERR_R
  } rmux_state_t;

endpackage

// File: rtl/axi_addr_decoder.sv
// Combinational base/mask address decoder; reports a hit and the lowest-index matching slave.
module axi_addr_decoder
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 2,
  parameter int SEL_W      = 1,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic [SEL_W-1:0]      sel_idx
);

  // Scan from the top down so the lowest-index match is the one left standing.
  always_comb begin
    hit     = 1'b0;
    sel_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit     = 1'b1;
        sel_idx = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/axi_read_slave_mux.sv
// Read-path slave mux: routes one master's AR/R channels to a decoded slave, one burst at a time.
// Optional AXI_RMUX_DECERR_EN: unmapped addresses get a local DECERR burst instead of slave 0.
module axi_read_slave_mux
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int USER_WIDTH = 1,
  parameter int NUM_SLAVES = 2,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = '0
) (
  input  logic                             ACLK,
  input  logic                             ARESETn,
  input  logic [ADDR_WIDTH-1:0]            m_ARADDR,
  input  logic [AXI_LEN_W-1:0]             m_ARLEN,
  input  logic [ID_WIDTH-1:0]              m_ARID,
  input  logic                             m_ARVALID,
  output logic                             m_ARREADY,
  output logic [ID_WIDTH-1:0]              m_RID,
  output logic [DATA_WIDTH-1:0]            m_RDATA,
  output logic [1:0]                       m_RRESP,
  output logic                             m_RLAST,
  output logic [USER_WIDTH-1:0]            m_RUSER,
  output logic                             m_RVALID,
  input  logic                             m_RREADY,
  output logic [NUM_SLAVES-1:0]            s_ARVALID,
  input  logic [NUM_SLAVES-1:0]            s_ARREADY,
  input  logic [NUM_SLAVES*ID_WIDTH-1:0]   s_RID,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_RDATA,
  input  logic [NUM_SLAVES*2-1:0]          s_RRESP,
  input  logic [NUM_SLAVES-1:0]            s_RLAST,
  input  logic [NUM_SLAVES*USER_WIDTH-1:0] s_RUSER,
  input  logic [NUM_SLAVES-1:0]            s_RVALID,
  output logic [NUM_SLAVES-1:0]            s_RREADY
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  rmux_state_t      state_q, state_d;
  logic [SEL_W-1:0] sel_idx_q, sel_idx_d;
  logic [SEL_W-1:0] dec_sel;
  logic             dec_hit;

`ifdef AXI_RMUX_DECERR_EN
  logic [AXI_LEN_W-1:0] len_q, len_d;
  logic [AXI_LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [ID_WIDTH-1:0]  id_q, id_d;
`else
  logic unused_ar;
  assign unused_ar = ^{m_ARLEN, m_ARID};
`endif

  axi_addr_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SEL_W),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK)
  ) u_decoder (
    .addr    (m_ARADDR),
    .hit     (dec_hit),
    .sel_idx (dec_sel)
  );

  always_comb begin
    state_d   = state_q;
    sel_idx_d = sel_idx_q;
`ifdef AXI_RMUX_DECERR_EN
    len_d      = len_q;
    id_d       = id_q;
    beat_cnt_d = beat_cnt_q;
`endif
    m_ARREADY = 1'b0;
    s_ARVALID = '0;
    s_RREADY  = '0;
    m_RVALID  = 1'b0;
    m_RID     = '0;
    m_RDATA   = '0;
    m_RRESP   = '0;
    m_RLAST   = 1'b0;
    m_RUSER   = '0;

    case (state_q)
      // The decode is registered here, which is what costs the one-cycle AR latency.
      IDLE: begin
        if (m_ARVALID) begin
`ifdef AXI_RMUX_DECERR_EN
          len_d     = m_ARLEN;
          id_d      = m_ARID;
          sel_idx_d = dec_sel;
          state_d   = dec_hit ? ADDR : ERR_AR;
`else
          sel_idx_d = dec_hit ? dec_sel : '0;
          state_d   = ADDR;
`endif
        end
      end

      ADDR: begin
        s_ARVALID[sel_idx_q] = m_ARVALID;
        m_ARREADY            = s_ARREADY[sel_idx_q];
        if (m_ARVALID && s_ARREADY[sel_idx_q]) begin
          state_d = DATA;
        end
      end

      DATA: begin
        m_RVALID            = s_RVALID[sel_idx_q];
        m_RID               = s_RID[int'(sel_idx_q)*ID_WIDTH +: ID_WIDTH];
        m_RDATA             = s_RDATA[int'(sel_idx_q)*DATA_WIDTH +: DATA_WIDTH];
        m_RRESP             = s_RRESP[int'(sel_idx_q)*2 +: 2];
        m_RLAST             = s_RLAST[sel_idx_q];
        m_RUSER             = s_RUSER[int'(sel_idx_q)*USER_WIDTH +: USER_WIDTH];
        s_RREADY[sel_idx_q] = m_RREADY;
        if (s_RVALID[sel_idx_q] && m_RREADY && s_RLAST[sel_idx_q]) begin
          state_d = IDLE;
        end
      end

`ifdef AXI_RMUX_DECERR_EN
      ERR_AR: begin
        m_ARREADY  = 1'b1;
        beat_cnt_d = '0;
        state_d    = ERR_R;
      end

      // beat_cnt stops at the latched length, so it never wraps past 255.
      ERR_R: begin
        m_RVALID = 1'b1;
        m_RRESP  = DECERR;
        m_RID    = id_q;
        m_RLAST  = (beat_cnt_q == len_q);
        if (m_RREADY) begin
          if (beat_cnt_q == len_q) begin
            state_d = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= IDLE;
      sel_idx_q  <= '0;
`ifdef AXI_RMUX_DECERR_EN
      len_q      <= '0;
      id_q       <= '0;
      beat_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sel_idx_q  <= sel_idx_d;
`ifdef AXI_RMUX_DECERR_EN
      len_q      <= len_d;
      id_q       <= id_d;
      beat_cnt_q <= beat_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_axi_read_slave_mux.sv
// Self-checking bench for axi_read_slave_mux: random bursts against a transaction-level reference model.
// Expectations follow AXI_RMUX_DECERR_EN the same way the DUT build does.
module tb_axi_read_slave_mux;

   localparam int NS  = 4;
   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int IDW = 2;
   localparam int UW  = 2;

   // Slave 2 overlaps slaves 0 and 1 entirely, so it must never win under lowest-index priority.
   localparam logic [AW-1:0] BASES [NS] = '{32'h0000_0000, 32'h1000_0000, 32'h0000_0000, 32'h3000_0000};
   localparam logic [AW-1:0] MASKS [NS] = '{32'hF000_0000, 32'hF000_0000, 32'hE000_0000, 32'hF000_0000};

   typedef struct packed {
      logic [DW-1:0]  data;
      logic [1:0]     resp;
      logic [IDW-1:0] id;
      logic [UW-1:0]  user;
      logic           last;
   } beat_t;

   logic ACLK = 1'b0;
   logic ARESETn;
   logic [AW-1:0]      m_araddr;
   logic [7:0]         m_arlen;
   logic [IDW-1:0]     m_arid;
   logic               m_arvalid;
   logic               m_arready;
   logic [IDW-1:0]     m_rid;
   logic [DW-1:0]      m_rdata;
   logic [1:0]         m_rresp;
   logic               m_rlast;
   logic [UW-1:0]      m_ruser;
   logic               m_rvalid;
   logic               m_rready;
   logic [NS-1:0]      s_arvalid;
   logic [NS-1:0]      s_arready;
   logic [NS*IDW-1:0]  s_rid;
   logic [NS*DW-1:0]   s_rdata;
   logic [NS*2-1:0]    s_rresp;
   logic [NS-1:0]      s_rlast;
   logic [NS*UW-1:0]   s_ruser;
   logic [NS-1:0]      s_rvalid;
   logic [NS-1:0]      s_rready;

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference-model state: what the master has asked for and what it is owed.
   bit    ar_pending;
   bit    burst_open;
   int    ar_age;
   int    tgt;
   int    txn_counter = 0;
   int    beats_seen;
   int    rready_mode;
   bit    force_junk0;
   beat_t sb[$];

   // Slave behavioural models.
   int             rem     [NS];
   int             beat_no [NS];
   int             slen    [NS];
   int             stxn    [NS];
   logic [IDW-1:0] sid     [NS];

   axi_read_slave_mux #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .ID_WIDTH   (IDW),
      .USER_WIDTH (UW),
      .NUM_SLAVES (NS),
      .SLV_BASE   ({32'h3000_0000, 32'h0000_0000, 32'h1000_0000, 32'h0000_0000}),
      .SLV_MASK   ({32'hF000_0000, 32'hE000_0000, 32'hF000_0000, 32'hF000_0000})
   ) dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .m_ARADDR  (m_araddr),
      .m_ARLEN   (m_arlen),
      .m_ARID    (m_arid),
      .m_ARVALID (m_arvalid),
      .m_ARREADY (m_arready),
      .m_RID     (m_rid),
      .m_RDATA   (m_rdata),
      .m_RRESP   (m_rresp),
      .m_RLAST   (m_rlast),
      .m_RUSER   (m_ruser),
      .m_RVALID  (m_rvalid),
      .m_RREADY  (m_rready),
      .s_ARVALID (s_arvalid),
      .s_ARREADY (s_arready),
      .s_RID     (s_rid),
      .s_RDATA   (s_rdata),
      .s_RRESP   (s_rresp),
      .s_RLAST   (s_rlast),
      .s_RUSER   (s_ruser),
      .s_RVALID  (s_rvalid),
      .s_RREADY  (s_rready)
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: observed no completion, expected $finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Address map rule: lowest-index slave whose masked address equals its base; -1 means DECERR.
   function automatic int routeOf(input logic [AW-1:0] addr);
      for (int i = 0; i < NS; i++) begin
         if ((addr & MASKS[i]) == BASES[i]) return i;
      end
`ifdef AXI_RMUX_DECERR_EN
      return -1;
`else
      return 0;
`endif
   endfunction

   // What slave s returns for beat b of transaction txn; used both to drive and to predict.
   function automatic beat_t slaveBeat(input int s, input int txn, input int b, input int len, input logic [IDW-1:0] id);
      beat_t r;
      r.data = {4'(s), 12'(txn), 16'(b)};
      r.resp = (s == 1) ? 2'(b & 1) : 2'b00;
      r.id   = id;
      r.user = UW'(s);
      r.last = (b == len);
      return r;
   endfunction

   task automatic clearModel();
      ar_pending  = 1'b0;
      burst_open  = 1'b0;
      force_junk0 = 1'b0;
      m_arvalid   = 1'b0;
      sb.delete();
      for (int i = 0; i < NS; i++) begin
         rem[i]     = 0;
         beat_no[i] = 0;
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_arready"}, m_arready, 0);
      checkOutput({tag, "_rvalid"}, m_rvalid, 0);
      checkOutput({tag, "_rfields"}, {m_rdata, m_rresp, m_rid, m_ruser, m_rlast}, 0);
      checkOutput({tag, "_s_arvalid"}, s_arvalid, 0);
      checkOutput({tag, "_s_rready"}, s_rready, 0);
   endtask

   // One clock: check at the falling edge, then advance models and drive just after the rising edge.
   task automatic cycleStep();
      logic          ar_hs, r_hs;
      logic [NS-1:0] s_ar_hs, s_r_hs, exp_mask;
      beat_t         got, exp_b, nb;
      @(negedge ACLK);
      ar_hs    = m_arvalid & m_arready;
      r_hs     = m_rvalid & m_rready;
      s_ar_hs  = s_arvalid & s_arready;
      s_r_hs   = s_rvalid & s_rready;
      exp_mask = (tgt >= 0) ? (NS'(1) << tgt) : '0;

      if (ar_pending) begin
         checkOutput("s_arvalid_route", s_arvalid & ~exp_mask, 0);
         if (ar_age == 0)   checkOutput("arready_decode_latency", m_arready, 0);
         else if (tgt >= 0) checkOutput("arready_fwd", m_arready, s_arready[tgt]);
         else               checkOutput("arready_err_pulse", m_arready, ar_age == 1);
         if (ar_hs && tgt >= 0) checkOutput("ar_onehot", s_arvalid, exp_mask);
      end else begin
         checkOutput("s_arvalid_idle", s_arvalid, 0);
         checkOutput("arready_idle", m_arready, 0);
      end

      if (burst_open) begin
         if (tgt >= 0) begin
            checkOutput("rvalid_fwd", m_rvalid, s_rvalid[tgt]);
            checkOutput("s_rready_fwd", s_rready, exp_mask & {NS{m_rready}});
         end else begin
            checkOutput("rvalid_err", m_rvalid, 1);
            checkOutput("s_rready_err", s_rready, 0);
         end
         if (r_hs) begin
            if (sb.size() == 0) begin
               checkOutput("r_extra_beat", r_hs, 0);
            end else begin
               exp_b = sb.pop_front();
               got   = {m_rdata, m_rresp, m_rid, m_ruser, m_rlast};
               checkOutput("r_beat", got, exp_b);
               beats_seen++;
               if (exp_b.last) burst_open = 1'b0;
            end
         end
      end else begin
         checkOutput("rvalid_idle", m_rvalid, 0);
         checkOutput("s_rready_idle", s_rready, 0);
         checkOutput("r_zero_idle", {m_rdata, m_rresp, m_rid, m_ruser, m_rlast}, 0);
      end

      if (ar_pending && ar_hs) begin
         for (int b = 0; b <= int'(m_arlen); b++) begin
            if (tgt >= 0) begin
               sb.push_back(slaveBeat(tgt, txn_counter, b, int'(m_arlen), m_arid));
            end else begin
               nb.data = '0;
               nb.resp = 2'b11;
               nb.id   = m_arid;
               nb.user = '0;
               nb.last = (b == int'(m_arlen));
               sb.push_back(nb);
            end
         end
         ar_pending = 1'b0;
         burst_open = 1'b1;
      end else if (ar_pending) begin
         ar_age++;
      end

      @(posedge ACLK);
      #1;
      if (ar_hs) m_arvalid = 1'b0;
      case (rready_mode)
         0:       m_rready = 1'b1;
         1:       m_rready = 1'($urandom_range(0, 1));
         default: m_rready = ~m_rready;
      endcase
      for (int i = 0; i < NS; i++) begin
         if (s_ar_hs[i]) begin
            rem[i]     = int'(m_arlen) + 1;
            slen[i]    = int'(m_arlen);
            beat_no[i] = 0;
            sid[i]     = m_arid;
            stxn[i]    = txn_counter;
         end else if (s_r_hs[i] && rem[i] > 0) begin
            rem[i]--;
            beat_no[i]++;
         end
         s_arready[i] = ($urandom_range(0, 9) < 7);
         if (rem[i] > 0) begin
            if (!(s_rvalid[i] && !s_r_hs[i])) s_rvalid[i] = ($urandom_range(0, 3) != 0);
            nb = slaveBeat(i, stxn[i], beat_no[i], slen[i], sid[i]);
            s_rdata[i*DW +: DW]   = nb.data;
            s_rresp[i*2 +: 2]     = nb.resp;
            s_rid[i*IDW +: IDW]   = nb.id;
            s_ruser[i*UW +: UW]   = nb.user;
            s_rlast[i]            = nb.last;
         end else begin
            s_rvalid[i]           = (force_junk0 && i == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
            s_rdata[i*DW +: DW]   = 32'hDEAD_0000 | DW'($urandom_range(0, 65535));
            s_rresp[i*2 +: 2]     = 2'($urandom);
            s_rid[i*IDW +: IDW]   = IDW'($urandom);
            s_ruser[i*UW +: UW]   = UW'($urandom);
            s_rlast[i]            = 1'($urandom);
         end
      end
   endtask

   task automatic startTxn(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IDW-1:0] id, input int mode);
      txn_counter++;
      tgt         = routeOf(addr);
      rready_mode = mode;
      m_araddr    = addr;
      m_arlen     = len;
      m_arid      = id;
      m_arvalid   = 1'b1;
      ar_pending  = 1'b1;
      ar_age      = 0;
      beats_seen  = 0;
   endtask

   task automatic resetDut();
      ARESETn  = 1'b0;
      clearModel();
      s_rvalid = '0;
      repeat (2) @(posedge ACLK);
      #1;
      ARESETn  = 1'b1;
   endtask

   // Runs one complete burst from AR presentation to its RLAST handshake.
   task automatic applyStimulus(input logic [AW-1:0] addr, input logic [7:0] len, input logic [IDW-1:0] id, input int mode);
      int  cycles = 0;
      bit  stuck;
      startTxn(addr, len, id, mode);
      while ((ar_pending || burst_open) && cycles < 3000) begin
         cycleStep();
         cycles++;
      end
      stuck = ar_pending || burst_open;
      checkOutput("txn_completes", stuck, 0);
      checkOutput("beat_count", beats_seen, int'(len) + 1);
      if (stuck) resetDut();
   endtask

   task automatic midBurstReset();
      int cycles = 0;
      startTxn(32'h1000_0000, 8'd3, 2'd1, 0);
      while (beats_seen < 2 && cycles < 500) begin
         cycleStep();
         cycles++;
      end
      checkOutput("mid_burst_reached", beats_seen, 2);
      s_rvalid = '1;
      #2;
      checkOutput("pre_reset_rvalid", m_rvalid, 1);
      ARESETn = 1'b0;
      #1;
      checkAllZero("rst_mid");
      clearModel();
      s_rvalid = '0;
      @(posedge ACLK);
      @(posedge ACLK);
      #1;
      ARESETn = 1'b1;
      applyStimulus(32'h0000_0200, 8'd3, 2'd2, 1);
   endtask

   initial begin
      logic [3:0] nibs [6];
      nibs      = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'hF};
      ARESETn   = 1'b1;
      m_araddr  = '0;
      m_arlen   = '0;
      m_arid    = '0;
      m_arvalid = 1'b0;
      m_rready  = 1'b1;
      s_arready = '1;
      s_rid     = '1;
      s_rdata   = '1;
      s_rresp   = '1;
      s_rlast   = '1;
      s_ruser   = '1;
      s_rvalid  = '1;
      tgt       = 0;
      clearModel();
      s_rvalid  = '1;
      #1;
      ARESETn = 1'b0;
      #2;
      checkAllZero("reset");
      @(posedge ACLK);
      @(posedge ACLK);
      #1;
      ARESETn  = 1'b1;
      s_rvalid = '0;

      force_junk0 = 1'b1;
      applyStimulus(32'h1000_0040, 8'd3, 2'd0, 0);
      force_junk0 = 1'b0;
      applyStimulus(32'h2000_0000, 8'd1, 2'd1, 0);
      applyStimulus(32'h0000_1000, 8'd7, 2'd2, 2);
      applyStimulus(32'h3000_0010, 8'd0, 2'd3, 1);
      applyStimulus(32'h4000_0000, 8'd255, 2'd3, 1);
      midBurstReset();

      for (int t = 0; t < 40; t++) begin
         logic [AW-1:0] a;
         a = {nibs[$urandom_range(0, 5)], 28'($urandom)};
         applyStimulus(a, 8'($urandom_range(0, 15)), IDW'($urandom), $urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
